// File: rtl/mem_banked_xbar_if.sv
// mem_banked_xbar_if: request/response bundle between the requesting ports
// and the banked memory crossbar.
//   v_i, w_i, addr_i, data_i, mask_i : per-port request (driven by master)
//   yumi_o                           : per-port accept, combinational (slave)
//   v_o, data_o                      : per-port response, one cycle later (slave)
// Parameters must match the ones given to mem_banked_xbar.
interface mem_banked_xbar_if #(
  parameter int unsigned num_ports_p  = 3,
  parameter int unsigned addr_width_p = 12,
  parameter int unsigned data_width_p = 32
);
  localparam int unsigned mask_width_lp = data_width_p / 8;

  logic [num_ports_p-1:0]                    v_i;
  logic [num_ports_p-1:0]                    w_i;
  logic [num_ports_p-1:0][addr_width_p-1:0]  addr_i;
  logic [num_ports_p-1:0][data_width_p-1:0]  data_i;
  logic [num_ports_p-1:0][mask_width_lp-1:0] mask_i;
  logic [num_ports_p-1:0]                    yumi_o;
  logic [num_ports_p-1:0]                    v_o;
  logic [num_ports_p-1:0][data_width_p-1:0]  data_o;

  modport master (
    output v_i, w_i, addr_i, data_i, mask_i,
    input  yumi_o, v_o, data_o
  );

  modport slave (
    input  v_i, w_i, addr_i, data_i, mask_i,
    output yumi_o, v_o, data_o
  );
endinterface

// File: rtl/mem_banked_xbar.sv
// mem_banked_xbar: multi-port, multi-bank synchronous SRAM crossbar.
// Each bank grants at most one requesting port per cycle; granted reads
// return data on the following cycle, v_o flags every grant one cycle later.
// Ports:
//   clk_i          : clock, rising edge
//   reset_i        : asynchronous active-high reset
//   bus            : mem_banked_xbar_if.slave request/response bundle
//   conflict_cnt_o : saturating count of cycles with a stalled request
//                    (only when MEM_BANKED_XBAR_CONFLICT_CNT_EN is defined)
// rr_lo_hi_p: 0 = highest index wins, 1 = lowest index wins, 2 = round-robin.
module mem_banked_xbar #(
  parameter int unsigned num_ports_p  = 3,
  parameter int unsigned num_banks_p  = 4,
  parameter int unsigned bank_size_p  = 1024,
  parameter int unsigned data_width_p = 32,
  parameter int unsigned rr_lo_hi_p   = 0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  mem_banked_xbar_if.slave     bus
`ifdef MEM_BANKED_XBAR_CONFLICT_CNT_EN
  ,
  output logic [31:0]          conflict_cnt_o
`endif
);

  localparam int unsigned bank_bits_lp  = $clog2(num_banks_p);
  localparam int unsigned off_bits_lp   = $clog2(bank_size_p);
  localparam int unsigned addr_width_lp = off_bits_lp + bank_bits_lp;
  localparam int unsigned mask_width_lp = data_width_p / 8;
  localparam int unsigned port_bits_lp  = (num_ports_p > 1) ? $clog2(num_ports_p) : 1;

  logic [num_ports_p-1:0][bank_bits_lp-1:0] port_bank;
  logic [num_ports_p-1:0][off_bits_lp-1:0]  port_off;

  logic [num_banks_p-1:0]                   gnt_v;
  logic [num_banks_p-1:0][port_bits_lp-1:0] gnt_p;
  logic [num_banks_p-1:0][off_bits_lp-1:0]  gnt_off;
  logic [num_banks_p-1:0]                   gnt_w;
  logic [num_banks_p-1:0][port_bits_lp-1:0] rr_ptr_q;
  logic [num_ports_p-1:0]                   yumi_c;

  logic [data_width_p-1:0] mem_r [num_banks_p][bank_size_p];

  // Address split into bank index (top bits) and bank offset (low bits).
  always_comb begin
    port_bank = '0;
    port_off  = '0;
    for (int p = 0; p < int'(num_ports_p); p++) begin
      port_bank[p] = bus.addr_i[p][addr_width_lp-1 -: bank_bits_lp];
      port_off[p]  = bus.addr_i[p][off_bits_lp-1:0];
    end
  end

  // Per-bank arbitration; scan order encodes the priority policy.
  always_comb begin
    int idx;
    gnt_v  = '0;
    gnt_p  = '0;
    yumi_c = '0;
    idx    = 0;
    for (int b = 0; b < int'(num_banks_p); b++) begin
      for (int i = 0; i < int'(num_ports_p); i++) begin
        if (rr_lo_hi_p == 2)      idx = (int'(rr_ptr_q[b]) + i) % int'(num_ports_p);
        else if (rr_lo_hi_p == 1) idx = i;
        else                      idx = int'(num_ports_p) - 1 - i;
        if (!gnt_v[b] && bus.v_i[port_bits_lp'(idx)]
            && (port_bank[port_bits_lp'(idx)] == bank_bits_lp'(b))) begin
          gnt_v[b] = 1'b1;
          gnt_p[b] = port_bits_lp'(idx);
        end
      end
      if (gnt_v[b]) yumi_c[gnt_p[b]] = 1'b1;
    end
    // No grants (and hence no memory writes) while reset is held.
    if (reset_i) begin
      gnt_v  = '0;
      yumi_c = '0;
    end
  end

  assign bus.yumi_o = yumi_c;

  // Route the winning port's offset and write enable to each bank.
  always_comb begin
    gnt_off = '0;
    gnt_w   = '0;
    for (int b = 0; b < int'(num_banks_p); b++) begin
      gnt_off[b] = port_off[gnt_p[b]];
      gnt_w[b]   = gnt_v[b] & bus.w_i[gnt_p[b]];
    end
  end

  // Bank storage with byte-masked writes; contents are not reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < int'(num_banks_p); b++) begin
      if (gnt_w[b]) begin
        for (int j = 0; j < int'(mask_width_lp); j++) begin
          if (bus.mask_i[gnt_p[b]][j])
            mem_r[b][gnt_off[b]][8*j +: 8] <= bus.data_i[gnt_p[b]][8*j +: 8];
        end
      end
    end
  end

  // Response valid, read data and round-robin pointers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bus.v_o    <= '0;
      bus.data_o <= '0;
      rr_ptr_q   <= '0;
    end else begin
      bus.v_o <= yumi_c;
      for (int p = 0; p < int'(num_ports_p); p++) begin
        if (yumi_c[p] && !bus.w_i[p])
          bus.data_o[p] <= mem_r[port_bank[p]][port_off[p]];
      end
      for (int b = 0; b < int'(num_banks_p); b++) begin
        if (gnt_v[b])
          rr_ptr_q[b] <= (gnt_p[b] == port_bits_lp'(num_ports_p - 1))
                         ? '0 : gnt_p[b] + 1'b1;
      end
    end
  end

`ifdef MEM_BANKED_XBAR_CONFLICT_CNT_EN
  logic any_stall_c;
  assign any_stall_c = |(bus.v_i & ~yumi_c);

  // Saturating count of cycles where some valid request was not accepted.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      conflict_cnt_o <= '0;
    else if (any_stall_c && (conflict_cnt_o != 32'hFFFF_FFFF))
      conflict_cnt_o <= conflict_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mem_banked_xbar.sv
// tb_mem_banked_xbar: directed checks of mem_banked_xbar with a fixed-priority
// instance (dut0, highest index wins) and a round-robin instance (dut2)
// driven with identical stimulus.
module tb_mem_banked_xbar;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_banked_xbar_if #(.num_ports_p(3), .addr_width_p(12), .data_width_p(32)) bus0 ();
  mem_banked_xbar_if #(.num_ports_p(3), .addr_width_p(12), .data_width_p(32)) bus2 ();

`ifdef MEM_BANKED_XBAR_CONFLICT_CNT_EN
  logic [31:0] cnt0;
  logic [31:0] cnt2;
`endif

  mem_banked_xbar #(
    .num_ports_p(3), .num_banks_p(4), .bank_size_p(1024),
    .data_width_p(32), .rr_lo_hi_p(0)
  ) dut0 (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus0)
`ifdef MEM_BANKED_XBAR_CONFLICT_CNT_EN
    ,
    .conflict_cnt_o (cnt0)
`endif
  );

  mem_banked_xbar #(
    .num_ports_p(3), .num_banks_p(4), .bank_size_p(1024),
    .data_width_p(32), .rr_lo_hi_p(2)
  ) dut2 (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus2)
`ifdef MEM_BANKED_XBAR_CONFLICT_CNT_EN
    ,
    .conflict_cnt_o (cnt2)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clear_req();
    bus0.v_i = '0; bus0.w_i = '0; bus0.addr_i = '0; bus0.data_i = '0; bus0.mask_i = '0;
    bus2.v_i = '0; bus2.w_i = '0; bus2.addr_i = '0; bus2.data_i = '0; bus2.mask_i = '0;
  endtask

  task automatic set_req(input int p, input logic w, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] m);
    bus0.v_i[p] = 1'b1; bus0.w_i[p] = w; bus0.addr_i[p] = a;
    bus0.data_i[p] = d; bus0.mask_i[p] = m;
    bus2.v_i[p] = 1'b1; bus2.w_i[p] = w; bus2.addr_i[p] = a;
    bus2.data_i[p] = d; bus2.mask_i[p] = m;
  endtask

  initial begin
    clear_req();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state, with a request presented during reset.
    set_req(0, 1'b0, 12'h000, 32'h0, 4'h0);
    #1;
    chk("rst_yumi",  64'(bus0.yumi_o), 64'h0);
    chk("rst_v_o",   64'(bus0.v_o), 64'h0);
    chk("rst_data0", 64'(bus0.data_o[0]), 64'h0);
    chk("rst_rr_v_o", 64'(bus2.v_o), 64'h0);
    @(negedge clk);
    clear_req();
    rst = 1'b0;

    // Parallel access: read bank0 and write bank1 in the same cycle.
    @(negedge clk);
    set_req(0, 1'b0, 12'h000, 32'h0, 4'h0);
    set_req(1, 1'b1, 12'h404, 32'hDEADBEEF, 4'hF);
    #1 chk("par_yumi", 64'(bus0.yumi_o), 64'h3);
    @(negedge clk);
    chk("par_v_o", 64'(bus0.v_o), 64'h3);
    clear_req();
    set_req(2, 1'b0, 12'h404, 32'h0, 4'h0);
    #1 chk("rd_yumi", 64'(bus0.yumi_o), 64'h4);
    @(negedge clk);
    chk("rd_v_o", 64'(bus0.v_o), 64'h4);
    chk("rd_data2", 64'(bus0.data_o[2]), 64'hDEADBEEF);
    chk("rd_data2_rr", 64'(bus2.data_o[2]), 64'hDEADBEEF);
    clear_req();

    // Byte mask, read right after write, then an all-zero-mask write.
    set_req(0, 1'b1, 12'hC10, 32'h11223344, 4'hF);
    #1 chk("bm_w1_yumi", 64'(bus0.yumi_o), 64'h1);
    @(negedge clk);
    clear_req();
    set_req(0, 1'b1, 12'hC10, 32'hAABBCCDD, 4'b0101);
    @(negedge clk);
    clear_req();
    set_req(1, 1'b0, 12'hC10, 32'h0, 4'h0);
    #1 chk("bm_rd_yumi", 64'(bus0.yumi_o), 64'h2);
    @(negedge clk);
    chk("bm_rd_v_o", 64'(bus0.v_o), 64'h2);
    chk("bm_data1", 64'(bus0.data_o[1]), 64'h11BB33DD);
    clear_req();
    set_req(2, 1'b1, 12'hC10, 32'hFFFFFFFF, 4'h0);
    #1 chk("nomask_yumi", 64'(bus0.yumi_o), 64'h4);
    @(negedge clk);
    chk("nomask_v_o", 64'(bus0.v_o), 64'h4);
    clear_req();
    set_req(1, 1'b0, 12'hC10, 32'h0, 4'h0);
    @(negedge clk);
    chk("nomask_data1", 64'(bus0.data_o[1]), 64'h11BB33DD);
    clear_req();

    // Fixed priority: highest index keeps winning while all requests are held.
    for (int p = 0; p < 3; p++) set_req(p, 1'b0, 12'h808, 32'h0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("fp_yumi", 64'(bus0.yumi_o), 64'h4);
      @(negedge clk);
      chk("fp_v_o", 64'(bus0.v_o), 64'h4);
    end

    // Asynchronous reset between edges while v_o is high.
    rst = 1'b1;
    #1;
    chk("arst_v_o",   64'(bus0.v_o), 64'h0);
    chk("arst_rr_v_o", 64'(bus2.v_o), 64'h0);
    chk("arst_yumi",  64'(bus0.yumi_o), 64'h0);
    chk("arst_data1", 64'(bus0.data_o[1]), 64'h0);
    clear_req();
    @(negedge clk);
    rst = 1'b0;

    // Round-robin: three ports held on one bank rotate 0, 1, 2.
    @(negedge clk);
    for (int p = 0; p < 3; p++) set_req(p, 1'b0, 12'h808, 32'h0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("rr_yumi", 64'(bus2.yumi_o), 64'(1 << k));
      @(negedge clk);
      chk("rr_v_o", 64'(bus2.v_o), 64'(1 << k));
    end
`ifdef MEM_BANKED_XBAR_CONFLICT_CNT_EN
    chk("cnt_rr", 64'(cnt2), 64'd3);
    chk("cnt_fp", 64'(cnt0), 64'd3);
`endif
    clear_req();
    rst = 1'b1;
    #1;
`ifdef MEM_BANKED_XBAR_CONFLICT_CNT_EN
    chk("cnt_rst", 64'(cnt2), 64'd0);
`endif
    chk("rr_rst_v_o", 64'(bus2.v_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_banked_xbar.md
Name: mem_banked_xbar

Overview:
- Multi-port, multi-bank synchronous SRAM crossbar used inside a manycore tile.
- It lets the core instruction port, the network remote-store port and the core data port share one banked local memory.
- Each cycle, every bank grants at most one requesting port through per-bank arbitration.
- Granted reads return data one cycle later.

Parameters:
- num_ports_p, 3: number of requesting ports.
- num_banks_p, 4: number of banks; must be a power of 2 and ≥2.
- bank_size_p, 1024: words per bank; must be a power of 2.
- data_width_p, 32: word width; must be a multiple of 8.
- rr_lo_hi_p, 0: arbitration policy.
  - 0: fixed priority, highest port index wins.
  - 1: fixed priority, lowest port index wins.
  - 2: round-robin.
- addr_width_lp, clog2(bank_size_p)+clog2(num_banks_p): derived word-address width.
- mask_width_lp, data_width_p/8: derived byte-mask width.

Ports:
- clk_i, in, 1: clock; all state updates on the rising edge.
- reset_i, in, 1: asynchronous, active-high reset.
- v_i, in, num_ports_p: per-port request valid.
- w_i, in, num_ports_p: per-port write enable (1 = write, 0 = read).
- addr_i, in, num_ports_p×addr_width_lp: per-port word address.
- data_i, in, num_ports_p×data_width_p: per-port write data.
- mask_i, in, num_ports_p×mask_width_lp: per-port byte write mask.
- yumi_o, out, num_ports_p: request accepted this cycle (combinational).
- v_o, out, num_ports_p: response valid, asserted one cycle after acceptance.
- data_o, out, num_ports_p×data_width_p: read data.

Behaviour:
- Address split:
  - Bank index is addr_i[addr_width_lp-1 -: clog2(num_banks_p)].
  - Bank offset is the low clog2(bank_size_p) bits.
- Per bank, the candidate set is the ports with v_i=1 whose bank index matches that bank. The bank grants one candidate according to rr_lo_hi_p.
- yumi_o[p] is 1 iff port p is granted in its bank. It is combinational from v_i/addr_i and the arbiter state.
- yumi_o[p] is never 1 when v_i[p]=0.
- Ports targeting different banks are all granted in the same cycle (full parallelism).
- A port that is not granted must hold its request; the block keeps no queue.
- Granted write:
  - Byte j of the addressed word is updated iff mask_i[p][j]=1.
  - mask all-zero means a no-op write, but the request is still acknowledged.
- Granted read: the addressed word appears on data_o[p] in the next cycle.
- v_o[p] is a register of yumi_o[p]; it asserts one cycle after every grant, read or write.
- data_o[p]:
  - Holds the most recent bank output routed to port p.
  - Is don't-care in a v_o cycle that follows a write grant.
  - Only the read cycle is checked.
- Read-during-write hazard: a read granted the cycle after a write to the same address returns the new data.
- A same-cycle same-bank read and write cannot occur, because only one port is granted per bank per cycle.
- Round-robin (rr_lo_hi_p=2):
  - Each bank keeps a last-grant pointer.
  - On a grant, priority for the next cycle starts at last_granted+1, modulo num_ports_p.
  - The pointer is unchanged when the bank makes no grant.
- Reset (asynchronous):
  - v_o is cleared to 0 and round-robin pointers to port 0.
  - data_o is cleared to 0.
  - Memory contents are not initialised; reads of unwritten words return X in simulation.
- yumi_o during reset is 0 for all ports.
- A reset asserted mid-operation discards in-flight responses: v_o falls to 0 immediately.

Optional Feature:
- Macro: MEM_BANKED_XBAR_CONFLICT_CNT_EN.
- When defined:
  - Adds output conflict_cnt_o, 32 bits.
  - The counter increments by 1 in every cycle in which any port has v_i=1 and yumi_o=0.
  - It saturates at 2^32-1 and clears on reset.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Parallel access: port0 reads addr 0x000 (bank0) while port1 writes 0xDEADBEEF with mask 4'hF to an address in bank1, same cycle → yumi_o=3'b011.
- Write-then-read: read port1's bank1 address next cycle from port2 → v_o[2]=1 with data_o[2]=0xDEADBEEF.
- Same-bank conflict, rr_lo_hi_p=0: ports 0, 1 and 2 all request bank2 → yumi_o=3'b100. Holding the requests gives grants 2, 2, 2, …
- Same-bank conflict, rr_lo_hi_p=2: all three ports are held on one bank for 3 cycles → grants rotate 0, 1, 2; each port's v_o follows its yumi_o by one cycle.
- Byte mask: write 0x11223344 with mask 4'hF, then write 0xAABBCCDD with mask 4'b0101, then read → 0x11BB33DD.
- Async reset mid-burst: assert reset_i between clock edges while v_o=1 → v_o=0 immediately, without waiting for a clock edge.
  - With MEM_BANKED_XBAR_CONFLICT_CNT_EN defined: after the 3-cycle conflict scenario the counter reads 3, and after reset it reads 0.
